adc_scan_sequencer: RTL and testbench

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_seq_pkg.sv | 38 +++
 rtl/adc_seq_accum.sv | 56 +++++
 rtl/adc_scan_sequencer.sv | 178 +++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types, constants and helpers for the ADC scan sequencer
package adc_seq_pkg;

    localparam int NCH_DEFAULT = 8;
    localparam int SAMPLE_W    = 12;

    // Bit positions inside the 6-bit LTC2308 configuration word.
    localparam int CONF_SD      = 5;
    localparam int CONF_ADDR_HI = 4;
    localparam int CONF_ADDR_LO = 2;
    localparam int CONF_UNI     = 1;
    localparam int CONF_SLP     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // LTC2308 single-ended address bits {O/S, S1, S0} for a channel number.
    function automatic logic [2:0] chan_addr(input logic [2:0] ch);
        return {ch[0], ch[2], ch[1]};
    endfunction

    // Lowest enabled channel at or above 'from'; bit 3 set means none found.
    function automatic logic [3:0] first_enabled(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] r;
        r = 4'b1000;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) begin
                r = {1'b0, 3'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_seq_accum.sv
// rtl/adc_seq_accum.sv - per-channel sample accumulator with shift averaging
//   clk, reset : clock, async active-high reset
//   clear      : drop any partial sum (new scan)
//   take       : accept sample this cycle
//   sample     : 12-bit conversion result
//   ready      : pulse with the sample that completes a 2^AVG_LOG2 group
//   result     : averaged value, valid while ready is high
module adc_seq_accum
    import adc_seq_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                take,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                ready,
    output logic [SAMPLE_W-1:0] result
);

    localparam int AW = SAMPLE_W + AVG_LOG2;
    localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          last;

    // The completing sample is folded in combinationally so the average is
    // available in the same cycle as the sample that finishes the group.
    assign sum    = acc + AW'(sample);
    assign last   = (cnt == CNT_LAST);
    assign ready  = take && last;
    assign result = SAMPLE_W'(sum >> AVG_LOG2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (take) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - scans enabled ADC channels, averages and stores results
//   clk, reset                  : clock, async active-high reset
//   start, stop, continuous     : scan control pulses / mode
//   chan_mask, uni              : channel enables and unipolar select, latched per scan
//   conf                        : configuration word to the ADC SPI controller
//   sample_valid, sample_data   : results returned by the ADC controller (one frame late)
//   rd_en, rd_chan              : result read request
//   rd_data, rd_valid, rd_fresh : registered read response and new-since-last-read flag
//   busy, scan_done             : activity flag, end-of-scan pulse
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NCH      = NCH_DEFAULT,
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic [7:0]          chan_mask,
    input  logic                uni,
    output logic [5:0]          conf,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                rd_en,
    input  logic [2:0]          rd_chan,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                rd_fresh,
    output logic                busy,
    output logic                scan_done
);

    localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CW-1:0] SLOT_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [7:0]    CH_OK     = 8'((1 << NCH) - 1);

    state_t              state, state_nx;
    logic [7:0]          mask_l;
    logic                uni_l, cont_l, stop_l;
    logic [2:0]          conf_ch, pend_ch;
    logic                pend_last;
    logic [CW-1:0]       slot_cnt;
    logic [SAMPLE_W-1:0] result_mem [NCH];
    logic [NCH-1:0]      fresh;

    logic                slot_pulse, slot_end, conf_last, scan_end, wrap;
    logic                start_ok, new_any, take, acc_ready;
    logic [3:0]          nxt_ch, new_first;
    logic [7:0]          new_mask;
    logic [SAMPLE_W-1:0] acc_res;

    // conf is held per slot for 2^AVG_LOG2 pulses; the prime pulse counts as
    // the first pulse of the first slot, its returned sample is just not used.
    assign slot_pulse = sample_valid && ((state == ST_PRIME) || (state == ST_SCAN));
    assign slot_end   = slot_pulse && (slot_cnt == SLOT_LAST);
    assign nxt_ch     = first_enabled(mask_l, {1'b0, conf_ch} + 4'd1);
    assign conf_last  = nxt_ch[3];
    assign new_mask   = chan_mask & CH_OK;
    assign new_first  = first_enabled(new_mask, 4'd0);
    assign new_any    = ~new_first[3];
    assign start_ok   = start && (state == ST_IDLE) && new_any;
    assign scan_end   = slot_end && conf_last;
    assign wrap       = scan_end && cont_l && !(stop_l || stop);
    assign take       = sample_valid && ((state == ST_SCAN) || (state == ST_DRAIN));

    adc_seq_accum #(.AVG_LOG2(AVG_LOG2)) u_accum (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_ok),
        .take   (take),
        .sample (sample_data),
        .ready  (acc_ready),
        .result (acc_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nx = ST_PRIME;
            ST_PRIME,
            ST_SCAN: begin
                if (scan_end) begin
                    state_nx = (wrap && new_any) ? ST_SCAN : ST_DRAIN;
                end else if (slot_pulse) begin
                    state_nx = ST_SCAN;
                end
            end
            ST_DRAIN: if (sample_valid) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        conf = '0;
        conf[CONF_SD]                    = 1'b1;
        conf[CONF_ADDR_HI:CONF_ADDR_LO]  = chan_addr(conf_ch);
        conf[CONF_UNI]                   = uni_l;
        conf[CONF_SLP]                   = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_l    <= '0;
            uni_l     <= 1'b0;
            cont_l    <= 1'b0;
            stop_l    <= 1'b0;
            conf_ch   <= '0;
            slot_cnt  <= '0;
            pend_ch   <= '0;
            pend_last <= 1'b0;
        end else if (start_ok) begin
            mask_l   <= new_mask;
            uni_l    <= uni;
            cont_l   <= continuous;
            stop_l   <= 1'b0;
            conf_ch  <= new_first[2:0];
            slot_cnt <= '0;
        end else begin
            if (stop && (state != ST_IDLE)) stop_l <= 1'b1;
            if ((state == ST_DRAIN) && sample_valid) stop_l <= 1'b0;
            if (slot_pulse) begin
                // The sample returned at the next pulse belongs to the channel
                // conf selects now; remember whether it closes the scan.
                pend_ch   <= conf_ch;
                pend_last <= conf_last;
                if (slot_end) begin
                    slot_cnt <= '0;
                    if (!conf_last) begin
                        conf_ch <= nxt_ch[2:0];
                    end else if (wrap && new_any) begin
                        mask_l  <= new_mask;
                        uni_l   <= uni;
                        conf_ch <= new_first[2:0];
                    end
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                end
            end
        end
    end

    // Results and read port. A read colliding with a write returns the old
    // value; the write's fresh set takes priority over the read's clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) result_mem[i] <= '0;
            fresh     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_fresh  <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            rd_valid  <= rd_en;
            scan_done <= acc_ready && pend_last;
            if (rd_en) begin
                rd_data        <= result_mem[rd_chan];
                rd_fresh       <= fresh[rd_chan];
                fresh[rd_chan] <= 1'b0;
            end
            if (acc_ready) begin
                result_mem[pend_ch] <= acc_res;
                fresh[pend_ch]      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - self-checking bench for adc_scan_sequencer
module tb_adc_scan_sequencer;

    localparam int AVG_LOG2 = 2;
    localparam int N        = 1 << AVG_LOG2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0, continuous = 1'b0, uni = 1'b0;
    logic [7:0]  chan_mask = '0;
    logic [5:0]  conf;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_data = '0;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_chan = '0;
    logic [11:0] rd_data;
    logic        rd_valid, rd_fresh, busy, scan_done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int exp_res [8];
    bit exp_fresh [8];
    int fixed_q [$];

    always #5 clk = ~clk;

    adc_scan_sequencer #(.NCH(8), .AVG_LOG2(AVG_LOG2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .chan_mask    (chan_mask),
        .uni          (uni),
        .conf         (conf),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .rd_en        (rd_en),
        .rd_chan      (rd_chan),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_fresh     (rd_fresh),
        .busy         (busy),
        .scan_done    (scan_done)
    );

    always @(negedge clk) if (scan_done === 1'b1) done_cnt++;

    // LTC2308 single-ended word: SD=1, O/S = odd channel, S1 = upper half, S0 = bit 1.
    function automatic logic [5:0] conf_model(input int ch, input bit u);
        return {1'b1, 1'(ch % 2), 1'(ch / 4), 1'((ch / 2) % 2), u, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
        end
    endtask

    task automatic read_chk(input int c, input string tag);
        rd_en = 1'b1;
        rd_chan = 3'(c);
        step();
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp_res[c]));
        check({tag, "_fresh"}, 32'(rd_fresh), 32'(exp_fresh[c]));
        exp_fresh[c] = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int c = 0; c < 8; c++) read_chk(c, tag);
    endtask

    // Runs nscans scans of mask m. Pulse 0 is the prime; pulse j>0 carries the
    // sample for conf slot j-1; each run of N samples averages into one result.
    task automatic run_scans(input logic [7:0] m, input bit u, input bit cont,
                             input int nscans, input bit rd_last);
        int chans [$];
        int len, slots, sum, g, d, done0, old_res, lastc;
        bit old_fresh;
        for (int c = 0; c < 8; c++) if (m[c]) chans.push_back(c);
        len = chans.size();
        slots = nscans * len * N;
        lastc = chans[len - 1];
        old_res = 0;
        old_fresh = 1'b0;
        sample_valid = 1'b1;
        sample_data = 12'hFFF;
        step();
        sample_valid = 1'b0;
        done0 = done_cnt;
        chan_mask = m;
        uni = u;
        continuous = cont;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        sum = 0;
        for (int j = 0; j <= slots; j++) begin
            if (cont && (j == (nscans - 1) * len * N + 1)) begin
                stop = 1'b1;
                step();
                stop = 1'b0;
            end
            d = (fixed_q.size() > 0) ? fixed_q.pop_front() : int'($urandom_range(0, 4095));
            if (j < slots) check("conf_slot", 32'(conf), 32'(conf_model(chans[(j / N) % len], u)));
            if (rd_last && (j == slots)) begin
                rd_en = 1'b1;
                rd_chan = 3'(lastc);
                old_res = exp_res[lastc];
                old_fresh = exp_fresh[lastc];
            end
            sample_valid = 1'b1;
            sample_data = 12'(d);
            step();
            sample_valid = 1'b0;
            rd_en = 1'b0;
            if (j >= 1) begin
                sum += d;
                if ((j - 1) % N == N - 1) begin
                    g = (j - 1) / N;
                    exp_res[chans[g % len]] = sum >> AVG_LOG2;
                    exp_fresh[chans[g % len]] = 1'b1;
                    sum = 0;
                end
            end
            if (rd_last && (j == slots)) begin
                check("collide_old_data", 32'(rd_data), 32'(old_res));
                check("collide_old_fresh", 32'(rd_fresh), 32'(old_fresh));
            end
            repeat ($urandom_range(0, 2)) step();
        end
        step();
        step();
        check("busy_after_scan", 32'(busy), 32'd0);
        check("scan_done_count", 32'(done_cnt - done0), 32'(nscans));
    endtask

    initial begin
        int done0;
        logic [7:0] m;
        for (int c = 0; c < 8; c++) begin
            exp_res[c] = 0;
            exp_fresh[c] = 1'b0;
        end
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_conf", 32'(conf), 32'h20);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_scan_done", 32'(scan_done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        chan_mask = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_mask_busy", 32'(busy), 32'd0);
        step();
        check("zero_mask_conf", 32'(conf), 32'h20);

        stop = 1'b1;
        step();
        stop = 1'b0;

        fixed_q = '{100, 200, 300, 400, 999};
        run_scans(8'h01, 1'b0, 1'b0, 1, 1'b0);
        rd_en = 1'b1;
        rd_chan = 3'd0;
        step();
        rd_en = 1'b0;
        check("s1_result", 32'(rd_data), 32'd474);
        check("s1_fresh", 32'(rd_fresh), 32'd1);
        exp_fresh[0] = 1'b0;

        run_scans(8'hA5, 1'b0, 1'b0, 1, 1'b0);
        chan_mask = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_mask_busy2", 32'(busy), 32'd0);
        check("zero_mask_conf_hold", 32'(conf), 32'(conf_model(7, 1'b0)));
        read_all("s2_rd");

        for (int k = 0; k < 3; k++) begin
            m = 8'($urandom_range(1, 255));
            run_scans(m, 1'($urandom_range(0, 1)), 1'b0, 1, 1'b0);
            read_all("rand_rd");
        end

        stop = 1'b1;
        step();
        stop = 1'b0;
        run_scans(8'h03, 1'b0, 1'b1, 2, 1'b0);
        read_chk(0, "s3_rd0");
        read_chk(1, "s3_rd1");
        m = 8'($urandom_range(1, 255));
        run_scans(m, 1'($urandom_range(0, 1)), 1'b1, 3, 1'b0);
        read_all("cont_rd");

        run_scans(8'h08, 1'b0, 1'b0, 1, 1'b0);
        read_chk(3, "s5_pre");
        run_scans(8'h08, 1'b1, 1'b0, 1, 1'b1);
        read_chk(3, "s5_new");
        read_chk(3, "s5_again");

        chan_mask = 8'hFF;
        uni = 1'b0;
        continuous = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sample_valid = 1'b1;
            sample_data = 12'($urandom_range(0, 4095));
            step();
            sample_valid = 1'b0;
        end
        done0 = done_cnt;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_conf", 32'(conf), 32'h20);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_scan_done", 32'(scan_done), 32'd0);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            exp_res[c] = 0;
            exp_fresh[c] = 1'b0;
        end
        step();
        check("midrst_no_done", 32'(done_cnt - done0), 32'd0);
        read_all("midrst_rd");
        m = 8'($urandom_range(1, 255));
        run_scans(m, 1'($urandom_range(0, 1)), 1'b0, 1, 1'b0);
        read_all("reprime_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
